// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage feeding the IF/ID pipeline buffer. Owns the PC and
//   keeps at most one request in flight to a variable-latency instruction
//   memory. It presents a registered {pc, instr} bundle that the IF/ID buffer
//   samples on every edge where hold is low. Empty slots are all-zero bubbles.
//
// Ports
//   i_clk          clock, all state updates on posedge
//   i_rst_n        asynchronous active-low reset
//   i_hold         downstream stall; presented bundle is frozen while high
//   i_redirect     taken branch/jump pulse; i_redirect_pc is the new PC
//   i_halt         stop issuing fetches (left only via redirect or reset)
//   o_imem_req     one-cycle request strobe, o_imem_addr is the PC register
//   i_imem_valid   one-cycle response strobe carrying i_imem_data
//   o_if_valid     bundle holds a real instruction
//   o_if_pc        address of the presented instruction
//   o_if_pc_next   o_if_pc + PC_STEP (wraps)
//   o_if_instr     presented instruction, zero when o_if_valid is low
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned          ADDR_W   = 16,
   parameter int unsigned          INSTR_W  = 16,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0,
   parameter int unsigned          PC_STEP  = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_hold,
   input  logic                i_redirect,
   input  logic [ADDR_W-1:0]   i_redirect_pc,
   input  logic                i_halt,
   output logic                o_imem_req,
   output logic [ADDR_W-1:0]   o_imem_addr,
   input  logic [INSTR_W-1:0]  i_imem_data,
   input  logic                i_imem_valid,
   output logic                o_if_valid,
   output logic [ADDR_W-1:0]   o_if_pc,
   output logic [ADDR_W-1:0]   o_if_pc_next,
   output logic [INSTR_W-1:0]  o_if_instr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_PRESENT,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t               r_state, w_state_nx;
   logic [ADDR_W-1:0]    r_pc, w_pc_nx;
   logic                 r_if_valid, w_if_valid_nx;
   logic [ADDR_W-1:0]    r_if_pc, w_if_pc_nx;
   logic [ADDR_W-1:0]    r_if_pc_next, w_if_pc_next_nx;
   logic [INSTR_W-1:0]   r_if_instr, w_if_instr_nx;

   logic [ADDR_W-1:0]    w_pc_inc;
   state_t               w_enter_req;

   assign w_pc_inc    = r_pc + ADDR_W'(PC_STEP);
   // Any non-redirect move into REQ is diverted to HALTED when halt is high,
   // so no request is ever issued once halt has been seen.
   assign w_enter_req = i_halt ? S_HALTED : S_REQ;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_if_valid   <= 1'b0;
         r_if_pc      <= '0;
         r_if_pc_next <= '0;
         r_if_instr   <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_pc         <= w_pc_nx;
         r_if_valid   <= w_if_valid_nx;
         r_if_pc      <= w_if_pc_nx;
         r_if_pc_next <= w_if_pc_next_nx;
         r_if_instr   <= w_if_instr_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_pc_nx         = r_pc;
      w_if_valid_nx   = r_if_valid;
      w_if_pc_nx      = r_if_pc;
      w_if_pc_next_nx = r_if_pc_next;
      w_if_instr_nx   = r_if_instr;

      if (i_redirect) begin
         // Redirect wins over hold/halt: new PC, bubble out this edge.
         w_pc_nx         = i_redirect_pc;
         w_if_valid_nx   = 1'b0;
         w_if_pc_nx      = '0;
         w_if_pc_next_nx = '0;
         w_if_instr_nx   = '0;
         case (r_state)
            S_REQ:   w_state_nx = S_DRAIN;
            // A response landing with the redirect is dropped and nothing is
            // left in flight, so a fresh request can go out immediately.
            S_WAIT,
            S_DRAIN: w_state_nx = i_imem_valid ? S_REQ : S_DRAIN;
            default: w_state_nx = S_REQ;
         endcase
      end else begin
         case (r_state)
            S_IDLE:    w_state_nx = w_enter_req;
            S_REQ:     w_state_nx = S_WAIT;
            S_WAIT: begin
               if (i_imem_valid) begin
                  w_if_valid_nx   = 1'b1;
                  w_if_pc_nx      = r_pc;
                  w_if_pc_next_nx = w_pc_inc;
                  w_if_instr_nx   = i_imem_data;
                  w_pc_nx         = w_pc_inc;
                  w_state_nx      = S_PRESENT;
               end
            end
            S_PRESENT: begin
               // Buffer consumes on this edge when hold is low.
               if (!i_hold) begin
                  w_if_valid_nx   = 1'b0;
                  w_if_pc_nx      = '0;
                  w_if_pc_next_nx = '0;
                  w_if_instr_nx   = '0;
                  w_state_nx      = w_enter_req;
               end
            end
            // Stale response of a redirected fetch: throw it away.
            S_DRAIN:   if (i_imem_valid) w_state_nx = w_enter_req;
            S_HALTED:  w_state_nx = S_HALTED;
            default:   w_state_nx = S_IDLE;
         endcase
      end
   end

   assign o_imem_req   = (r_state == S_REQ);
   assign o_imem_addr  = r_pc;
   assign o_if_valid   = r_if_valid;
   assign o_if_pc      = r_if_pc;
   assign o_if_pc_next = r_if_pc_next;
   assign o_if_instr   = r_if_instr;

endmodule
